alu_seq: RTL

Parametrised sequential ALU with valid/ready handshakes on both sides, status flags and an iterative multiplier. It extends the earlier fixed-width add/sub datapath with eight operations, back-pressure and a multi-cycle operation path. It sits between a command source (for example a UART command decoder) and a result consumer, and processes one operation at a time.

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, status flags and an iterative
// shift-add multiplier; one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     diff_s;
  logic [WIDTH-1:0]     res_s;
  logic                 res_carry_s;
  logic                 res_ovf_s;
  logic [2*WIDTH-1:0]   addend_s;
  logic [2*WIDTH-1:0]   acc_sum_s;

  // Single-cycle datapath evaluated on the captured operands.
  always_comb begin
    sum_s       = {1'b0, a_q} + {1'b0, b_q};
    diff_s      = a_q - b_q;
    res_s       = '0;
    res_carry_s = 1'b0;
    res_ovf_s   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_s       = sum_s[WIDTH-1:0];
        res_carry_s = sum_s[WIDTH];
        res_ovf_s   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_s       = diff_s;
        res_carry_s = (a_q < b_q);
        res_ovf_s   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res_s = a_q & b_q;
      OP_OR:  res_s = a_q | b_q;
      OP_XOR: res_s = a_q ^ b_q;
      OP_SHL: begin
        if (b_q >= SHIFT_LIM) begin
          res_s = '0;
        end else begin
          res_s = a_q << b_q;
        end
      end
      OP_SHR: begin
        if (b_q >= SHIFT_LIM) begin
          res_s = '0;
        end else begin
          res_s = a_q >> b_q;
        end
      end
      default: res_s = '0;
    endcase
  end

  // One shift-add step: multiplicand shifted by the bit index selected by the counter.
  always_comb begin
    if (b_q[cnt_q]) begin
      addend_s = {{WIDTH{1'b0}}, a_q} << cnt_q;
    end else begin
      addend_s = '0;
    end
    acc_sum_s = acc_q + addend_s;
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op_in;
          a_d     = a_in;
          b_d     = b_in;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (op_in == OP_MUL) ? S_MUL : S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        out_d   = res_s;
        carry_d = res_carry_s;
        ovf_d   = res_ovf_s;
        zero_d  = (res_s == '0);
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_MUL: begin
        acc_d = acc_sum_s;
        if (cnt_q == CNT_LAST) begin
          out_d   = acc_sum_s[WIDTH-1:0];
          carry_d = 1'b0;
          ovf_d   = |acc_sum_s[2*WIDTH-1:WIDTH];
          zero_d  = (acc_sum_s[WIDTH-1:0] == '0);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_OUT;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_MUL;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out       = out_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_valid = valid_q;

endmodule
